// File: rtl/hmac_engine_arbiter_if.sv
// Requester/engine bundle for hmac_engine_arbiter. The arbiter takes the slave view;
// the environment (requesters plus the lw_hmac engine) takes the master view.
// Handshake rule: a word moves on a clock edge where its valid and ready are both
// high; valid and the payload hold steady until then, and ready never waits on valid.
interface hmac_engine_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int WORD_SIZE = 64
);
  logic [N_REQ-1:0]                 req_i;
  logic [N_REQ-1:0][3:0]            opcode_i;
  logic [N_REQ-1:0]                 new_key_i;
  logic [N_REQ-1:0][WORD_SIZE-1:0]  data_i;
  logic [N_REQ-1:0]                 data_valid_i;
  logic [N_REQ-1:0]                 last_i;
  logic [N_REQ-1:0][WORD_SIZE-1:0]  key_i;
  logic [N_REQ-1:0]                 key_valid_i;
  logic [N_REQ-1:0]                 abort_i;
  logic [N_REQ-1:0]                 gnt_o;
  logic [N_REQ-1:0]                 ready_o;
  logic [N_REQ-1:0]                 key_ready_o;
  logic [N_REQ-1:0]                 done_o;
  logic [N_REQ-1:0]                 err_o;
  logic [7:0][WORD_SIZE-1:0]        hash_o;

  logic                  eng_start_o;
  logic                  eng_abort_o;
  logic                  eng_last_o;
  logic                  eng_data_valid_o;
  logic [WORD_SIZE-1:0]  eng_data_o;
  logic [3:0]            eng_opcode_o;
  logic [WORD_SIZE-1:0]  eng_key_o;
  logic                  eng_key_valid_o;
  logic                  eng_new_key_o;
  logic                  eng_ready_i;
  logic                  eng_key_ready_i;
  logic                  eng_core_ready_i;
  logic                  eng_done_i;
  logic [7:0][WORD_SIZE-1:0] eng_hash_i;

  modport slave (
    input  req_i, opcode_i, new_key_i, data_i, data_valid_i, last_i,
           key_i, key_valid_i, abort_i,
           eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_hash_i,
    output gnt_o, ready_o, key_ready_o, done_o, err_o, hash_o,
           eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_data_o,
           eng_opcode_o, eng_key_o, eng_key_valid_o, eng_new_key_o
  );

  modport master (
    output req_i, opcode_i, new_key_i, data_i, data_valid_i, last_i,
           key_i, key_valid_i, abort_i,
           eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_hash_i,
    input  gnt_o, ready_o, key_ready_o, done_o, err_o, hash_o,
           eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_data_o,
           eng_opcode_o, eng_key_o, eng_key_valid_o, eng_new_key_o
  );
endinterface

// File: rtl/hmac_engine_arbiter.sv
// Per-message round-robin arbiter sharing one lw_hmac engine between N_REQ requesters,
// with saved-key ownership tracking so only the key's loader may reuse it.
module hmac_engine_arbiter #(
  parameter int N_REQ     = 2,
  parameter int WORD_SIZE = 64
) (
  input  logic                        clk_i,
  input  logic                        aresetn_i,
  hmac_engine_arbiter_if.slave        bus,
  output logic [2:0]                  o_dbg_state,
  output logic [$clog2(N_REQ)-1:0]    o_dbg_rr_ptr,
  output logic                        o_dbg_key_owner_vld,
  output logic [$clog2(N_REQ)-1:0]    o_dbg_key_owner
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [PW-1:0]             r_rr_ptr;
  logic [PW-1:0]             r_owner;
  logic [PW-1:0]             r_key_owner;
  logic                      r_key_owner_vld;
  logic [3:0]                r_opcode;
  logic                      r_new_key;
  logic                      r_eng_abort;
  logic [N_REQ-1:0]          r_gnt;
  logic [N_REQ-1:0]          r_done;
  logic [N_REQ-1:0]          r_err;
  logic [7:0][WORD_SIZE-1:0] r_hash;

  logic                      w_any;
  logic [PW-1:0]             w_win;
  logic [PW-1:0]             w_cand;
  logic [3:0]                w_opc;
  logic                      w_nk;
  logic                      w_reject;
  logic                      w_active;
  logic                      w_done;
  logic                      w_own_abort;
  logic                      w_own_valid;

  // Search begins one past the last winner, so every requester is reached within N_REQ jobs.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_rr_ptr;
    w_cand = r_rr_ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = PW'((int'(r_rr_ptr) + i) % N_REQ);
      if (!w_any && bus.req_i[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_opc    = bus.opcode_i[w_win];
  assign w_nk     = bus.new_key_i[w_win];
  assign w_reject = (w_opc[3:2] == 2'b11) ||
                    (w_opc[0] && !w_nk && (!r_key_owner_vld || (r_key_owner != w_win)));

  assign w_active    = (r_state == S_START) || (r_state == S_BUSY);
  assign w_done      = w_active && bus.eng_done_i;
  assign w_own_abort = w_active && bus.abort_i[r_owner];
  assign w_own_valid = bus.data_valid_i[r_owner];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|bus.req_i && bus.eng_core_ready_i) w_next = S_ARB;
      S_ARB:   w_next = (!w_any || w_reject) ? S_IDLE : S_START;
      S_START: begin
        if (w_done)           w_next = S_IDLE;
        else if (w_own_abort) w_next = S_DRAIN;
        else if (w_own_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_done)           w_next = S_IDLE;
        else if (w_own_abort) w_next = S_DRAIN;
      end
      // The abort pulse is still on the wire in the first drain cycle; wait it out.
      S_DRAIN: if (bus.eng_core_ready_i && !r_eng_abort) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state         <= S_IDLE;
      r_rr_ptr        <= PW'(N_REQ - 1);
      r_owner         <= '0;
      r_key_owner     <= '0;
      r_key_owner_vld <= 1'b0;
      r_opcode        <= '0;
      r_new_key       <= 1'b0;
      r_eng_abort     <= 1'b0;
      r_gnt           <= '0;
      r_done          <= '0;
      r_err           <= '0;
      r_hash          <= '0;
    end else begin
      r_state     <= w_next;
      r_done      <= '0;
      r_err       <= '0;
      r_eng_abort <= 1'b0;
      unique case (r_state)
        S_ARB: begin
          if (w_any) begin
            r_rr_ptr <= w_win;
            if (w_reject) begin
              r_err <= N_REQ'(1) << w_win;
            end else begin
              r_owner   <= w_win;
              r_opcode  <= w_opc;
              r_new_key <= w_nk;
              r_gnt     <= N_REQ'(1) << w_win;
            end
          end
        end
        S_START, S_BUSY: begin
          // Done outranks a same-cycle abort: the digest is already complete.
          if (w_done) begin
            r_hash <= bus.eng_hash_i;
            r_done <= N_REQ'(1) << r_owner;
            r_gnt  <= '0;
            if (r_opcode[0] && r_new_key) begin
              r_key_owner     <= r_owner;
              r_key_owner_vld <= 1'b1;
            end
          end else if (w_own_abort) begin
            r_eng_abort <= 1'b1;
            r_gnt       <= '0;
            if (r_opcode[0] && r_new_key) r_key_owner_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.eng_start_o      = 1'b0;
    bus.eng_last_o       = 1'b0;
    bus.eng_data_valid_o = 1'b0;
    bus.eng_data_o       = '0;
    bus.eng_opcode_o     = '0;
    bus.eng_key_o        = '0;
    bus.eng_key_valid_o  = 1'b0;
    bus.eng_new_key_o    = 1'b0;
    bus.ready_o          = '0;
    bus.key_ready_o      = '0;
    if (w_active) begin
      bus.eng_start_o      = (r_state == S_START);
      bus.eng_last_o       = bus.last_i[r_owner];
      bus.eng_data_valid_o = bus.data_valid_i[r_owner];
      bus.eng_data_o       = bus.data_i[r_owner];
      bus.eng_opcode_o     = r_opcode;
      bus.eng_key_o        = bus.key_i[r_owner];
      bus.eng_key_valid_o  = bus.key_valid_i[r_owner];
      bus.eng_new_key_o    = r_new_key;
      bus.ready_o          = N_REQ'(bus.eng_ready_i) << r_owner;
      bus.key_ready_o      = N_REQ'(bus.eng_key_ready_i) << r_owner;
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.hash_o      = r_hash;
  assign bus.eng_abort_o = r_eng_abort;

  assign o_dbg_state         = r_state;
  assign o_dbg_rr_ptr        = r_rr_ptr;
  assign o_dbg_key_owner_vld = r_key_owner_vld;
  assign o_dbg_key_owner     = r_key_owner;
endmodule

// File: doc/hmac_engine_arbiter.md
# hmac_engine_arbiter

Shares one `lw_hmac` engine between `N_REQ` independent requesters, for example a CPU register port and a DMA port. Requests are granted per message in round-robin order. The granted requester's data, key and abort streams are routed to the engine, and the engine's handshakes and digest are routed back to it. The block tracks which requester loaded the engine's saved HMAC key and refuses saved-key HMAC jobs from any other requester. It sits between the requester ports and the engine, and is the only driver of the engine's inputs.

## Interface
- `N_REQ`, 2: number of requesters (2..4).
- `WORD_SIZE`, 64: data/key word width; equals engine `` `WORD_SIZE``.
- `clk_i` in 1: clock.
- `aresetn_i` in 1: reset, asynchronous, active-low.
- `req_i` in N_REQ: level request, held until `done_o`/`err_o`/abort.
- `opcode_i` in N_REQ×4: per-requester opcode; bit0 selects HMAC, bits[3:1] select mode.
- `new_key_i` in N_REQ: requester supplies a new key (1) or uses the saved key (0).
- `data_i` in N_REQ×WORD_SIZE, `data_valid_i` in N_REQ, `last_i` in N_REQ: message stream.
- `key_i` in N_REQ×WORD_SIZE, `key_valid_i` in N_REQ: key stream.
- `abort_i` in N_REQ: abort the job (honoured only from the owner).
- `gnt_o` out N_REQ: one-hot, high for the whole job.
- `ready_o`, `key_ready_o` out N_REQ: engine handshakes gated to the owner.
- `done_o`, `err_o` out N_REQ: one-cycle pulses.
- `hash_o` out 8×WORD_SIZE: last delivered digest; valid when `done_o` pulses.
- Engine side, outputs: `eng_start_o`, `eng_abort_o`, `eng_last_o`, `eng_data_valid_o`, `eng_data_o`, `eng_opcode_o[3:0]`, `eng_key_o`, `eng_key_valid_o`, `eng_new_key_o`.
- Engine side, inputs: `eng_ready_i`, `eng_key_ready_i`, `eng_core_ready_i`, `eng_done_i`, `eng_hash_i[7:0]`.

## Operation
- Registered FSM with four states: IDLE, ARB, START, BUSY. A DRAIN state handles abort recovery.
- **IDLE**
  - Go to ARB when any `req_i` bit is high and `eng_core_ready_i`=1.
- **ARB**
  - Select the winner round-robin. Search starts at index `rr_ptr+1` (mod N_REQ). `rr_ptr` is updated to the winner.
  - Reject the winner when either condition holds:
    - `opcode[3:2]`=2'b11 (illegal mode).
    - HMAC with `new_key`=0, and either `key_owner_vld`=0 or `key_owner`≠winner.
  - On reject: pulse `err_o[w]` and return to IDLE.
  - Otherwise: latch winner, opcode and `new_key`; assert `gnt_o[w]`; go to START.
- **START**
  - Drive `eng_start_o`=1, the latched opcode and `eng_new_key_o`.
  - Data/valid/last/key come from the owner.
  - When `eng_data_valid_o`=1 in this state, go to BUSY.
- **BUSY**
  - Pure mux from the owner; `eng_start_o`=0.
  - `ready_o[w]`=`eng_ready_i` and `key_ready_o[w]`=`eng_key_ready_i`; all other bits are 0.
  - Non-owner `abort_i` is ignored.
- **Completion**
  - On `eng_done_i`: latch `eng_hash_i` into `hash_o` and pulse `done_o[w]`.
  - If the job was HMAC with `new_key`=1: set `key_owner`=w and `key_owner_vld`=1.
  - Drop `gnt_o`; go to IDLE.
- **Abort**
  - On `abort_i[w]` in START or BUSY: `eng_abort_o`=1 for one cycle; drop `gnt_o`; go to DRAIN.
  - If the job was HMAC with `new_key`=1, clear `key_owner_vld` (the key is partially loaded).
- **DRAIN**
  - Wait for `eng_core_ready_i`=1, then go to IDLE. No `done_o` is issued.
- While no requester is granted, all `eng_*` outputs except `eng_abort_o` are 0.

## Timing
- Reset values:
  - All outputs 0; `hash_o` = 0.
  - `rr_ptr` = N_REQ-1, so requester 0 wins first.
  - `key_owner_vld` = 0.
  - State = IDLE.
- Request-to-grant latency:
  - `req_i` high with the engine idle: `gnt_o` rises 2 cycles later (IDLE→ARB→START).
  - `err_o` pulses in the cycle after ARB.
- `eng_done_i` at cycle t: `done_o` and `hash_o` are registered at t+1.
  - `gnt_o` is low from t+1.
  - The next grant comes no earlier than t+3.
- Simultaneous `eng_done_i` and `abort_i[w]`: done wins (digest delivered). The engine already ignores abort at done.
- Requester keeping `req_i` high after `done_o` is treated as a new request in round-robin order.
- Asynchronous reset mid-job: all state clears; the engine is reset by the same `aresetn_i`.

## Test plan
- **Round-robin:**
  - Stimulus: `req_i`=2'b11 continuously, SHA-256 (opcode 4'b0000), 1-block messages.
  - Required: grants alternate 0,1,0,1; each `done_o` matches the golden SHA-256 of "abc".
- **Key ownership:**
  - Stimulus: req0 HMAC with `new_key`=1, then req1 HMAC with `new_key`=0.
  - Required: `err_o[1]` pulses, no `eng_start_o`.
  - Then req0 with `new_key`=0: HMAC digest matches RFC 4231 case 2.
- **Illegal opcode:**
  - Stimulus: `opcode_i`=4'b1101.
  - Required: `err_o` pulses 2 cycles after the request; `rr_ptr` advances; the engine stays idle.
- **Abort:**
  - Stimulus: owner aborts in BUSY after 3 words.
  - Required: `eng_abort_o` pulses for one cycle, no `done_o`, `key_owner_vld`=0, next grant only after `eng_core_ready_i`.
- **Non-owner abort:**
  - Stimulus: `abort_i[1]` while req0 is busy.
  - Required: ignored; req0 digest is correct.
- **Reset mid-job:**
  - Stimulus: `aresetn_i` low during BUSY.
  - Required: all outputs 0; after release, req1 alone is granted 2 cycles after its `req_i`.
